// File: rtl/uart_rx_byte.sv
// UART 8N1 byte receiver: one write strobe per good frame, frame_err on a bad stop bit.
// Optional even-parity frame (8E1) when UART_RX_PARITY_EN is defined.
module uart_rx_byte #(
    parameter int unsigned CLK_HZ = 100000000,
    parameter int unsigned BAUD   = 115200
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] data_out,
    output logic       write,
    output logic       frame_err,
    output logic       busy
);

    localparam int unsigned CPB  = CLK_HZ / BAUD;
    localparam int unsigned HALF = CPB / 2;
    localparam int unsigned CW   = $clog2(CPB);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
    localparam logic [2:0] S_STOP   = 3'd3;
    localparam logic [2:0] S_BREAK  = 3'd4;
`ifdef UART_RX_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd5;
`endif

    logic          rx_m, rx_s;
    logic [2:0]    state, state_nx;
    logic [CW-1:0] cnt, cnt_nx;
    logic [2:0]    bit_idx, bit_idx_nx;
    logic [7:0]    shift, shift_nx;
    logic [7:0]    data_nx;
    logic          write_nx, ferr_nx;
    logic          par_err, par_err_nx;

    wire sample_bit = (cnt == CW'(CPB - 1));

    // State and output registers; the rx synchroniser resets to idle-high
    always_ff @(posedge clk) begin
        if (!rst) begin
            rx_m      <= 1'b1;
            rx_s      <= 1'b1;
            state     <= S_IDLE;
            cnt       <= '0;
            bit_idx   <= '0;
            shift     <= '0;
            par_err   <= 1'b0;
            data_out  <= '0;
            write     <= 1'b0;
            frame_err <= 1'b0;
            busy      <= 1'b0;
        end else begin
            rx_m      <= rx;
            rx_s      <= rx_m;
            state     <= state_nx;
            cnt       <= cnt_nx;
            bit_idx   <= bit_idx_nx;
            shift     <= shift_nx;
            par_err   <= par_err_nx;
            data_out  <= data_nx;
            write     <= write_nx;
            frame_err <= ferr_nx;
            busy      <= (state_nx != S_IDLE);
        end
    end

    // Next-state and next-output logic; counter cleared at every sample point
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt + CW'(1);
        bit_idx_nx = bit_idx;
        shift_nx   = shift;
        par_err_nx = par_err;
        data_nx    = data_out;
        write_nx   = 1'b0;
        ferr_nx    = 1'b0;

        case (state)
            S_IDLE: begin
                cnt_nx = '0;
                if (!rx_s) begin
                    state_nx = S_START;
                end
            end
            S_START: begin
                if (cnt == CW'(HALF - 1)) begin
                    cnt_nx = '0;
                    if (!rx_s) begin
                        state_nx   = S_DATA;
                        bit_idx_nx = '0;
                        par_err_nx = 1'b0;
                    end else begin
                        state_nx = S_IDLE;
                    end
                end
            end
            S_DATA: begin
                if (sample_bit) begin
                    cnt_nx     = '0;
                    shift_nx   = {rx_s, shift[7:1]};
                    bit_idx_nx = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) begin
`ifdef UART_RX_PARITY_EN
                        state_nx = S_PARITY;
`else
                        state_nx = S_STOP;
`endif
                    end
                end
            end
`ifdef UART_RX_PARITY_EN
            S_PARITY: begin
                if (sample_bit) begin
                    cnt_nx     = '0;
                    par_err_nx = ^{shift, rx_s};
                    state_nx   = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (sample_bit) begin
                    cnt_nx = '0;
                    if (rx_s) begin
                        state_nx = S_IDLE;
                        if (par_err) begin
                            ferr_nx = 1'b1;
                        end else begin
                            data_nx  = shift;
                            write_nx = 1'b1;
                        end
                    end else begin
                        ferr_nx  = 1'b1;
                        state_nx = S_BREAK;
                    end
                end
            end
            S_BREAK: begin
                // Held-low line must return high before a new start edge counts
                cnt_nx = '0;
                if (rx_s) begin
                    state_nx = S_IDLE;
                end
            end
            default: begin
                cnt_nx   = '0;
                state_nx = S_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_rx_byte.sv
// Self-checking bench for uart_rx_byte: directed and random frames against a byte-level model.
module tb_uart_rx_byte;

    localparam int unsigned CLK_HZ = 16;
    localparam int unsigned BAUD   = 1;
    localparam int          CPB    = CLK_HZ / BAUD;
    localparam int          HALF   = CPB / 2;
`ifdef UART_RX_PARITY_EN
    localparam int          FRAME_BITS = 10;
`else
    localparam int          FRAME_BITS = 9;
`endif
    // pin edge -> write: 2 synchroniser clocks, 1 detect clock, registered strobe
    localparam int          LAT = HALF + FRAME_BITS * CPB + 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       rx;
    logic [7:0] data_out;
    logic       write;
    logic       frame_err;
    logic       busy;

    uart_rx_byte #(.CLK_HZ(CLK_HZ), .BAUD(BAUD)) dut (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .data_out  (data_out),
        .write     (write),
        .frame_err (frame_err),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic [7:0] wr_q[$];
    int         wr_cyc_q[$];
    int         ferr_n    = 0;
    int         excl_bad  = 0;
    int         long_bad  = 0;
    logic       write_d   = 1'b0;
    logic       ferr_d    = 1'b0;

    // Output monitor, sampled on the falling edge
    always @(negedge clk) begin
        if (write) begin
            wr_q.push_back(data_out);
            wr_cyc_q.push_back(cyc);
        end
        if (frame_err) ferr_n++;
        if (write && frame_err) excl_bad++;
        if ((write && write_d) || (frame_err && ferr_d)) long_bad++;
        write_d = write;
        ferr_d  = frame_err;
    end

    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    int         exp_ferr  = 0;
    int         last_start = 0;
    int         n_checks  = 0;
    int         n_pass    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bit_out(input logic v);
        rx = v;
        wait_clks(CPB);
    endtask

    // Drive one frame and record what the receiver should report for it
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input logic bad_par);
        last_start = cyc;
        bit_out(1'b0);
        for (int i = 0; i < 8; i++) bit_out(b[i]);
`ifdef UART_RX_PARITY_EN
        bit_out((^b) ^ bad_par);
`endif
        bit_out(stop_bit);
        if (!stop_bit || bad_par) begin
            exp_ferr++;
        end else begin
            exp_q.push_back(b);
            last_good = b;
        end
    endtask

    task automatic drain(input string tag);
        check({tag, "_nwrites"}, 32'(wr_q.size()), 32'(exp_q.size()));
        while (wr_q.size() > 0 && exp_q.size() > 0)
            check({tag, "_byte"}, 32'(wr_q.pop_front()), 32'(exp_q.pop_front()));
        check({tag, "_data_out"}, 32'(data_out), 32'(last_good));
        check({tag, "_ferr_cnt"}, 32'(ferr_n), 32'(exp_ferr));
        wr_q.delete();
        exp_q.delete();
        wr_cyc_q.delete();
    endtask

    initial begin
        int          lat;
        logic [31:0] word;
        int          p;
        logic [7:0]  rb;
        logic        rs;

        rst = 1'b0;
        rx  = 1'b1;
        wait_clks(3);
        check("rst_data_out", 32'(data_out), 32'h0);
        check("rst_write", 32'(write), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        rst = 1'b1;
        wait_clks(CPB);

        // Single byte with latency measurement
        send_frame(8'h12, 1'b1, 1'b0);
        lat = (wr_cyc_q.size() > 0) ? wr_cyc_q[0] - last_start : -1;
        check("single_latency", 32'(lat), 32'(LAT));
        wait_clks(4);
        check("single_busy_idle", 32'(busy), 32'h0);
        drain("single");

        // Back-to-back frames with one-bit stops
        send_frame(8'h12, 1'b1, 1'b0);
        send_frame(8'h34, 1'b1, 1'b0);
        send_frame(8'h56, 1'b1, 1'b0);
        send_frame(8'h78, 1'b1, 1'b0);
        wait_clks(4);
        word = (wr_q.size() >= 4) ? {wr_q[0], wr_q[1], wr_q[2], wr_q[3]} : 32'h0;
        check("b2b_word", word, 32'h12345678);
        drain("b2b");

        // Start glitch of 4 clocks
        p = cyc;
        rx = 1'b0;
        wait_clks(4);
        rx = 1'b1;
        wait_clks(6);
        check("glitch_cyc", 32'(cyc - p), 32'd10);
        check("glitch_busy_mid", 32'(busy), 32'h1);
        wait_clks(1);
        check("glitch_busy_idle", 32'(busy), 32'h0);
        wait_clks(CPB);
        send_frame(8'hA5, 1'b1, 1'b0);
        wait_clks(4);
        drain("glitch");

        // Bad stop bit, then line held low
        send_frame(8'hA5, 1'b0, 1'b0);
        rx = 1'b0;
        wait_clks(40);
        check("break_busy", 32'(busy), 32'h1);
        check("break_nwrites", 32'(wr_q.size()), 32'h0);
        rx = 1'b1;
        wait_clks(CPB);
        check("break_released", 32'(busy), 32'h0);
        check("break_data_held", 32'(data_out), 32'(last_good));
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_clks(4);
        drain("ferr");

        // Reset after data bit 3 of 0xFF
        bit_out(1'b0);
        repeat (4) bit_out(1'b1);
        rst = 1'b0;
        wait_clks(1);
        rst = 1'b1;
        last_good = 8'h00;
        check("midrst_data_out", 32'(data_out), 32'h0);
        check("midrst_write", 32'(write), 32'h0);
        check("midrst_frame_err", 32'(frame_err), 32'h0);
        check("midrst_busy", 32'(busy), 32'h0);
        wait_clks(6 * CPB);
        send_frame(8'h3C, 1'b1, 1'b0);
        wait_clks(4);
        drain("midrst");

`ifdef UART_RX_PARITY_EN
        send_frame(8'h0F, 1'b1, 1'b0);
        wait_clks(4);
        drain("par_good");
        send_frame(8'h0F, 1'b1, 1'b1);
        wait_clks(4);
        drain("par_bad");
`endif

        // Random bytes with occasional bad stops and random gaps
        for (int i = 0; i < 10; i++) begin
            rb = 8'($urandom);
            rs = ($urandom_range(3) != 0);
            send_frame(rb, rs, 1'b0);
            if (!rs) begin
                rx = 1'b0;
                wait_clks($urandom_range(30));
                rx = 1'b1;
                wait_clks(CPB);
            end else begin
                wait_clks($urandom_range(5));
            end
        end
        wait_clks(4);
        drain("rand");

        check("write_ferr_exclusive", 32'(excl_bad), 32'h0);
        check("single_cycle_pulses", 32'(long_bad), 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
